// File: rtl/arbitro_escritura_reg.sv
// -----------------------------------------------------------------------------
// arbitro_escritura_reg
//
// Purpose:
//   Shares the single write port of the 32x32 register file between two
//   writeback sources (0 = ALU, 1 = load unit). Arbitration is round-robin,
//   and the write port is driven from registered outputs. The block also keeps
//   a per-register bitmap of outstanding loads. Decode uses that bitmap to
//   stall, and the ALU path uses it to avoid overtaking a pending load (WAW).
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   alu_valid/alu_addr/alu_data        ALU writeback request
//   alu_ready                          ALU request accepted this cycle (comb.)
//   mem_valid/mem_addr/mem_data        load writeback request
//   mem_ready                          load request accepted this cycle (comb.)
//   reserva_en/reserva_addr            load issued: mark destination pending
//   addr1, addr2                       decode-stage read addresses
//   bloqueo                            stall decode (comb.)
//   write_en/write_addr/write_data     register file write port (registered)
//   pendientes                         number of pending registers (registered)
// -----------------------------------------------------------------------------
module arbitro_escritura_reg #(
  parameter int ANCHO_DATOS = 32,
  parameter int ANCHO_DIR   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [ANCHO_DIR-1:0]   alu_addr,
  input  logic [ANCHO_DATOS-1:0] alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ANCHO_DIR-1:0]   mem_addr,
  input  logic [ANCHO_DATOS-1:0] mem_data,
  output logic                   mem_ready,
  input  logic                   reserva_en,
  input  logic [ANCHO_DIR-1:0]   reserva_addr,
  input  logic [ANCHO_DIR-1:0]   addr1,
  input  logic [ANCHO_DIR-1:0]   addr2,
  output logic                   bloqueo,
  output logic                   write_en,
  output logic [ANCHO_DIR-1:0]   write_addr,
  output logic [ANCHO_DATOS-1:0] write_data,
  output logic [5:0]             pendientes
);

  localparam int NUM_REG = 1 << ANCHO_DIR;

  // State
  logic [NUM_REG-1:0]     pendiente_q, pendiente_d;
  logic                   ultimo_q, ultimo_d;
  logic                   write_en_q, write_en_d;
  logic [ANCHO_DIR-1:0]   write_addr_q, write_addr_d;
  logic [ANCHO_DATOS-1:0] write_data_q, write_data_d;
  logic                   origen_mem_q, origen_mem_d;
  logic [5:0]             pendientes_q, pendientes_d;

  // Arbitration
  logic alu_eleg, mem_eleg;
  logic grant_alu, grant_mem;

  // One-hot set/clear vectors for the scoreboard
  logic [NUM_REG-1:0] set_vec, clr_vec;
  logic               inc, dec;

  // ---------------------------------------------------------------------------
  // Eligibility and round-robin grant
  // ---------------------------------------------------------------------------
  always_comb begin
    // An ALU write to a register with an outstanding load must wait. Otherwise
    // the late load would overwrite the newer ALU value.
    alu_eleg  = alu_valid & ~pendiente_q[alu_addr];
    mem_eleg  = mem_valid;
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_eleg && mem_eleg) begin
      // The source that was not served last wins.
      grant_alu = ultimo_q;
      grant_mem = ~ultimo_q;
    end else begin
      grant_alu = alu_eleg;
      grant_mem = mem_eleg;
    end
  end

  // While reset is asserted, no request may be accepted because the accepted
  // write would be discarded.
  assign alu_ready = rst_n & grant_alu;
  assign mem_ready = rst_n & grant_mem;

  // ---------------------------------------------------------------------------
  // Write stage next state
  // ---------------------------------------------------------------------------
  always_comb begin
    write_en_d   = 1'b0;
    origen_mem_d = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    ultimo_d     = ultimo_q;
    if (grant_alu) begin
      write_addr_d = alu_addr;
      write_data_d = alu_data;
      write_en_d   = (alu_addr != '0);
      ultimo_d     = 1'b0;
    end else if (grant_mem) begin
      write_addr_d = mem_addr;
      write_data_d = mem_data;
      // A load to x0 has nothing to commit and nothing to release.
      write_en_d   = (mem_addr != '0);
      origen_mem_d = 1'b1;
      ultimo_d     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  // The clear fires on the same edge that the register file commits the load
  // data. Bit 0 is never set, because x0 is hard-wired.
  for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_marcas
    assign set_vec[gi] = reserva_en & (reserva_addr == ANCHO_DIR'(gi)) & (gi != 0);
    assign clr_vec[gi] = write_en_q & origen_mem_q & (write_addr_q == ANCHO_DIR'(gi));
  end

  always_comb begin
    // The set is applied after the clear, so a new reservation wins over the
    // release of an older load to the same register.
    pendiente_d = (pendiente_q & ~clr_vec) | set_vec;

    // Count real bit transitions only. Re-reserving a pending bit, clearing a
    // bit that was not pending, or setting and clearing the same address
    // leaves the count unchanged.
    inc = |(set_vec & ~pendiente_q);
    dec = |(clr_vec & pendiente_q & ~set_vec);

    pendientes_d = pendientes_q;
    case ({inc, dec})
      2'b10:   pendientes_d = pendientes_q + 6'd1;
      2'b01:   pendientes_d = pendientes_q - 6'd1;
      default: pendientes_d = pendientes_q;
    endcase
  end

  assign bloqueo = ((addr1 != '0) & pendiente_q[addr1]) |
                   ((addr2 != '0) & pendiente_q[addr2]);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendiente_q  <= '0;
      ultimo_q     <= 1'b1;  // the ALU wins the first contention
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      origen_mem_q <= 1'b0;
      pendientes_q <= '0;
    end else begin
      pendiente_q  <= pendiente_d;
      ultimo_q     <= ultimo_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      origen_mem_q <= origen_mem_d;
      pendientes_q <= pendientes_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign pendientes = pendientes_q;

endmodule

// File: doc/arbitro_escritura_reg.md
# arbitro_escritura_reg

Write-port arbiter and load scoreboard for the 32x32 register file (`conjunto_reg__32x32`) of the RV32I core. Two writeback sources share the register file's single write port through valid/ready handshakes with round-robin priority: source 0 is the ALU, source 1 is the load unit. The block drives the register file's `write_en`/`write_addr`/`write_data` from registered outputs. A per-register pending bitmap (scoreboard) stalls the decode stage while a read address has an outstanding load.

## Interface
- `ANCHO_DATOS`, 32: data width.
- `ANCHO_DIR`, 5: register address width (32 registers).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `alu_valid`  in  1: ALU writeback request.
- `alu_addr`  in  ANCHO_DIR: ALU destination register.
- `alu_data`  in  ANCHO_DATOS: ALU result.
- `alu_ready`  out  1: ALU request accepted this cycle (combinational).
- `mem_valid`  in  1: load writeback request.
- `mem_addr`  in  ANCHO_DIR: load destination register.
- `mem_data`  in  ANCHO_DATOS: load data.
- `mem_ready`  out  1: load request accepted this cycle (combinational).
- `reserva_en`  in  1: load issued; mark `reserva_addr` pending.
- `reserva_addr`  in  ANCHO_DIR: destination of the issued load.
- `addr1`, `addr2`  in  ANCHO_DIR: decode-stage read addresses.
- `bloqueo`  out  1: stall decode (combinational).
- `write_en`  out  1: register file write enable (registered).
- `write_addr`  out  ANCHO_DIR: register file write address (registered).
- `write_data`  out  ANCHO_DATOS: register file write data (registered).
- `pendientes`  out  6: count of pending registers, 0..31 (registered).

## Operation
- Handshake: a request completes on the cycle where `valid` and `ready` are both 1. A requester holds `valid`, `addr` and `data` stable until `ready` goes high. `ready` is never 1 while its `valid` is 0.
- Eligibility:
  - The ALU is eligible when `alu_valid` is 1 and `pendiente[alu_addr]` is 0. This is the WAW guard: an ALU write never overtakes an outstanding load to the same register.
  - The load unit is eligible when `mem_valid` is 1.
- Arbitration:
  - Only one source is eligible: it is granted.
  - Both are eligible: the source not granted last (`ultimo`) wins.
  - `ultimo` updates on every grant to the index of the granted source.
- Write stage, at the clock edge after a grant:
  - `write_addr` and `write_data` take the granted request's values.
  - `write_en` is 1 only if that address is nonzero.
  - Writes to x0 are accepted (ready=1) but produce `write_en`=0.
  - With no grant, `write_en` is 0 and addr/data hold their previous values.
- Internal flag `origen_mem` is registered alongside `write_en` and records that the stage holds a load writeback.
- Scoreboard `pendiente[31:0]`:
  - Set: `reserva_en` is 1 and `reserva_addr` is nonzero. Bit 0 is never set.
  - Clear: `write_en` and `origen_mem` are both 1; clears bit `write_addr`. This is the same edge on which the register file commits the data.
  - Set and clear to the same address in the same cycle: set wins.
  - Reserving an already-pending register leaves the bit at 1.
- `pendientes` counter:
  - Increments when a bit goes 0→1.
  - Decrements when a bit goes 1→0.
  - Unchanged when the set and clear are the same address, or when both happen on different addresses in the same cycle.
  - Never wraps.
- `bloqueo` = (addr1≠0 & pendiente[addr1]) | (addr2≠0 & pendiente[addr2]).

## Timing
- Reset, while `rst_n`=0, asynchronous:
  - `write_en`=0, `write_addr`=0, `write_data`=0, `pendientes`=0.
  - `pendiente`=0 and `origen_mem`=0.
  - `ultimo`=1, so the ALU wins the first contention.
- Reset mid-operation discards the in-flight write stage and all pending bits. Requesters re-present after reset.
- `alu_ready`, `mem_ready` and `bloqueo` are combinational from the current inputs and state, with no cycle of latency.
- Latency:
  - Handshake at edge T → `write_en` high in cycle T..T+1 → register file writes at edge T+1.
  - For a load, `pendiente` clears at edge T+1. `bloqueo` falls in the cycle after T+1, when the register file's combinational read returns the new data.
- `reserva_en` at edge T: `bloqueo` for that address rises in the cycle after edge T.
- Throughput: one write per cycle. Under continuous contention the sources alternate.

## Test plan
- Reset: hold `rst_n`=0 with requests active → all outputs 0, `alu_ready`=`mem_ready`=0. Release → first contention grants the ALU.
- Single ALU write: `alu_valid`=1, addr=1, data=32'hDEADBEEF → `alu_ready`=1 the same cycle; next cycle `write_en`=1, `write_addr`=1, `write_data`=32'hDEADBEEF; then `write_en`=0.
- Contention: both valid for 4 cycles, ALU addr=2, load addr=3 → grants alternate ALU, load, ALU, load. `write_addr` sequence is 2, 3, 2, 3.
- x0 write: ALU addr=0, data=32'h12345678 → `alu_ready`=1 and `write_en` stays 0.
- Scoreboard:
  - `reserva_en` with addr=5, then `addr1`=5 → `bloqueo`=1 and `pendientes`=1.
  - ALU request to addr 5 → `alu_ready`=0.
  - Load to addr 5 handshakes at T → `bloqueo`=0 after edge T+1, `pendientes`=0, and the ALU request is then accepted.
- Simultaneous set and clear: in the same cycle, reserve addr 7 while the write stage commits a load to addr 7 → `pendiente[7]` stays 1 and `pendientes` is unchanged.
